// File: rtl/instr_fetch_reg_pkg.sv
// Shared constants for the 8-bit RISC fetch path: field widths, the opcode set
// and the fetch FSM state encoding.
package instr_fetch_reg_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OPC_W_DEF  = 3;
  localparam int unsigned ADDR_W_DEF = 13;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_HI   = 2'b00,
    ST_LO   = 2'b01,
    ST_FULL = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_reg.sv
// Instruction fetch register: assembles two ROM bytes (high first) into one
// instruction, advances the PC per accepted byte and holds the word for the controller.
module instr_fetch_reg
  import instr_fetch_reg_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       OPC_W   = OPC_W_DEF,
  parameter int unsigned       ADDR_W  = ADDR_W_DEF,
  parameter logic [OPC_W-1:0]  HLT_OPC = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              flush,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  output logic              rom_ready,
  output logic              pc_inc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              halted
);

  localparam int unsigned IR_W = 2 * DATA_W;

  fetch_state_e      state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              accept_s;

  // Byte handshake; reset also blocks acceptance so the PC never moves while reset is applied.
  always_comb begin
    rom_ready = ena & ~flush & ~halted_q & ~rst &
                ((state_q == ST_HI) | (state_q == ST_LO));
    accept_s  = rom_valid & rom_ready;
    pc_inc    = accept_s;
  end

  // Next-state logic for the fetch FSM, instruction register, valid and halt flags.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (flush) begin
      // A jump reloaded the PC: drop the partial/held word but leave ir contents as-is.
      state_d = ST_HI;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_HI: begin
          if (accept_s) begin
            ir_d[IR_W-1:DATA_W] = rom_data;
            state_d             = ST_LO;
          end else begin
            state_d = ST_HI;
          end
        end
        ST_LO: begin
          if (accept_s) begin
            ir_d[DATA_W-1:0] = rom_data;
            valid_d          = 1'b1;
            state_d          = ST_FULL;
          end else begin
            state_d = ST_LO;
          end
        end
        ST_FULL: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            state_d = ST_HI;
            if (ir_q[IR_W-1 -: OPC_W] == HLT_OPC) begin
              halted_d = 1'b1;
            end else begin
              halted_d = halted_q;
            end
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_HI;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HI;
      ir_q     <= {IR_W{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign instr_valid = valid_q;
  assign opcode      = ir_q[IR_W-1 -: OPC_W];
  assign ir_addr     = ir_q[ADDR_W-1:0];
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
Instruction fetch register that consumes the byte stream from program ROM at the address driven by the program counter.
- Assembles two consecutive bytes (high first) into one instruction word.
- Splits the word into opcode and operand address.
- Pulses the PC advance strobe once per accepted byte.
- Holds the word until the machine controller accepts it.
- Sits between ROM/counter and the controller/decode path of the 8-bit RISC core.

Parameters:
- DATA_W, 8, ROM byte width.
- OPC_W, 3, opcode field width (instruction MSBs).
- ADDR_W, 13, operand address field width. OPC_W+ADDR_W must equal 2*DATA_W.
- HLT_OPC, 3'b000, opcode value that halts fetching.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  fetch enable from machine controller.
- flush  in  1  discard partial/held instruction (asserted in the cycle the PC is loaded by a jump).
- rom_data  in  DATA_W  byte from ROM.
- rom_valid  in  1  rom_data valid this cycle.
- rom_ready  out  1  byte will be accepted this cycle.
- pc_inc  out  1  advance PC by one (combinational, equals byte accept).
- instr_valid  out  1  opcode/ir_addr hold a complete instruction.
- instr_ready  in  1  consumer takes the instruction.
- opcode  out  OPC_W  ir[2*DATA_W-1 -: OPC_W].
- ir_addr  out  ADDR_W  ir[ADDR_W-1:0].
- halted  out  1  sticky; HLT instruction accepted.

Behaviour:
- Reset (rst=1 at posedge) has the highest priority. Resulting values: state=HI, ir=0, instr_valid=0, halted=0. Therefore opcode=0 and ir_addr=0. Reset mid-instruction drops any captured byte.
- States:
  - HI: wait for high byte.
  - LO: wait for low byte.
  - FULL: instruction held.
- rom_ready = ena & ~flush & ~halted & (state==HI | state==LO). It is 0 in FULL.
- accept = rom_valid & rom_ready. pc_inc = accept, in the same cycle, so the counter advances on the same edge the byte is captured.
- HI + accept: ir[15:8] <= rom_data; next state LO.
- LO + accept: ir[7:0] <= rom_data; instr_valid <= 1; next state FULL. Latency: instr_valid rises the cycle after the second accept.
- FULL + instr_ready: instr_valid <= 0; next state HI. If opcode==HLT_OPC, halted <= 1.
- FULL + ~instr_ready: hold. opcode and ir_addr must be stable.
- HI or LO with ~accept: hold state and ir.
- ena=0: no accepts. State and ir hold. A held FULL instruction may still be taken by instr_ready.
- flush=1 (not reset): next state HI, instr_valid <= 0, pc_inc=0. ir holds its old value and is not cleared. Flush beats a simultaneous rom_valid (byte dropped, PC not advanced) and a simultaneous instr_ready (instruction not taken, halted not set).
- halted: set only as above. Cleared only by rst. While set, rom_ready=0 and pc_inc=0.
- No fetch overlap: at most 2 accepted bytes per instruction. Minimum throughput is one instruction per 3 cycles with rom_valid=1 and instr_ready=1.

Decomposition:
- Shared package/include holds the opcode constants (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP), DATA_W/ADDR_W defaults, and the state encoding (HI=2'b00, LO=2'b01, FULL=2'b10).
- Single module; no sub-module is warranted. The FSM and the 16-bit ir register are inline.

Test Plan:
- Reset: rst=1 for one edge with rom_valid=1 and rom_data=8'hFF → instr_valid=0, opcode=0, ir_addr=0, halted=0, pc_inc=0 during reset.
- Fetch: ena=1, rom_valid=1, bytes 8'hA3 then 8'h5C, instr_ready=0 → pc_inc high exactly 2 cycles. Next cycle: instr_valid=1, opcode=3'b101, ir_addr=13'h035C. Held 5 cycles, rom_ready=0, no further pc_inc.
- Back-pressure/accept: from FULL raise instr_ready for 1 cycle → instr_valid=0 next cycle. Next bytes 8'h20, 8'h10 → opcode=3'b001, ir_addr=13'h0010.
- Flush mid-instruction: accept 8'hE0, then flush=1 with rom_valid=1 and data 8'h11 → pc_inc=0, state HI. Next bytes 8'h40, 8'h07 → opcode=3'b010, ir_addr=13'h0007 (8'hE0 discarded).
- Stall: ena=0 between the two bytes for 4 cycles → no pc_inc, and the instruction assembles correctly after ena returns.
- Halt: fetch 8'h00, 8'h00, then accept → halted=1. rom_ready stays 0 for 10 cycles with rom_valid=1. rst=1 → halted=0 and fetching resumes.
